// File: rtl/stack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stack_pkg                                                    |
// | Description : Shared definitions for the stack controller: FSM state       |
// |               encoding, push/pop operation codes and default sizing.       |
// |               The REJECT state exists only with STACK_CTRL_BOUNDS_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package stack_pkg;

  localparam int DEPTH_DEF = 1024;
  localparam int DW_DEF    = 32;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_WR  = 3'd1,
    POP_RD   = 3'd2,
    POP_RESP = 3'd3
`ifdef STACK_CTRL_BOUNDS_EN
    ,
    REJECT   = 3'd4
`endif
  } state_e;

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_ctrl_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arb2                                                      |
// | Description : Two-input round-robin arbiter. On a conflict the requester   |
// |               not granted last wins; requester 0 wins the first conflict   |
// |               after reset. The priority pointer moves only when advance    |
// |               is high and a grant is actually issued.                      |
// | Ports       : clk, reset      - clock, synchronous active-high reset       |
// |               req[1:0]        - request vector                             |
// |               advance         - grant is being consumed this cycle         |
// |               gnt[1:0]        - combinational one-hot (or zero) grant      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // prio_q = 0 favours requester 0, 1 favours requester 1.
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    // Whoever just won gets lowest priority next time.
    if (advance && (gnt != 2'b00)) begin
      prio_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/stack_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stack_ctrl                                                   |
// | Description : Two-requester LIFO controller in front of a synchronous      |
// |               single-port RAM (one-cycle read latency). Push takes 2       |
// |               cycles (grant, write), pop takes 3 (grant, read, response).  |
// | Ports       : clk, reset           - clock, synchronous active-high reset  |
// |               req/op/wdata         - per-requester request, op, push data  |
// |               gnt/done/rdata/err   - grant, completion, pop data, reject   |
// |               mem_we/addr/wdata    - RAM write enable, address, data       |
// |               mem_rdata            - RAM read data                         |
// |               sp/full/empty        - entry count and status                |
// | Macro       : STACK_CTRL_BOUNDS_EN - enables overflow/underflow rejection  |
// |               (REJECT state, err, full). Without it sp wraps modulo DEPTH. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req,
  input  logic [1:0]      op,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      done,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic [AW:0]     sp,
  output logic            full,
  output logic            empty
);

`ifdef STACK_CTRL_BOUNDS_EN
  localparam int SPW = AW + 1;   // must represent DEPTH itself
`else
  localparam int SPW = AW;       // wraps modulo DEPTH
`endif

  state_e          state_q, state_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic            who_q, who_d;     // index of the requester being served
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            done_pulse;

  logic            arb_en;
  logic [1:0]      arb_req;
  logic [1:0]      arb_gnt;
  logic            sel_op;
  logic [DW-1:0]   sel_wdata;
  logic [SPW-1:0]  sp_m1;

  // Arbitration only runs in IDLE and never while reset is asserted, so gnt
  // cannot pulse during reset or while an operation is in flight.
  assign arb_en  = (state_q == IDLE) && !reset;
  assign arb_req = req & {2{arb_en}};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (arb_en),
    .gnt     (arb_gnt)
  );

  assign sel_op    = arb_gnt[1] ? op[1] : op[0];
  assign sel_wdata = arb_gnt[1] ? wdata[2*DW-1:DW] : wdata[DW-1:0];
  assign sp_m1     = sp_q - SPW'(1);

  assign sp    = (AW+1)'(sp_q);
  assign empty = (sp_q == '0);
`ifdef STACK_CTRL_BOUNDS_EN
  assign full  = (sp_q == SPW'(DEPTH));
`else
  assign full  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    who_d      = who_q;
    wdata_d    = wdata_q;
    gnt        = 2'b00;
    done_pulse = 1'b0;
    err        = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = sp_q[AW-1:0];
    mem_wdata  = wdata_q;
    rdata      = '0;

    case (state_q)
      IDLE: begin
        gnt = arb_gnt;
        if (arb_gnt != 2'b00) begin
          who_d   = arb_gnt[1];
          wdata_d = sel_wdata;
          state_d = (sel_op == OP_POP) ? POP_RD : PUSH_WR;
`ifdef STACK_CTRL_BOUNDS_EN
          if (((sel_op == OP_PUSH) && full) || ((sel_op == OP_POP) && empty)) begin
            state_d = REJECT;
          end
`endif
        end
      end
      PUSH_WR: begin
        mem_we     = 1'b1;
        mem_addr   = sp_q[AW-1:0];
        done_pulse = 1'b1;
        sp_d       = sp_q + SPW'(1);
        state_d    = IDLE;
      end
      POP_RD: begin
        mem_addr = sp_m1[AW-1:0];
        state_d  = POP_RESP;
      end
      POP_RESP: begin
        // Keep the address steady; the read data belongs to the POP_RD address.
        mem_addr   = sp_m1[AW-1:0];
        done_pulse = 1'b1;
        rdata      = mem_rdata;
        sp_d       = sp_m1;
        state_d    = IDLE;
      end
`ifdef STACK_CTRL_BOUNDS_EN
      REJECT: begin
        done_pulse = 1'b1;
        err        = 1'b1;
        state_d    = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign done = done_pulse ? (who_q ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sp_q    <= '0;
      who_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      who_q   <= who_d;
      wdata_q <= wdata_d;
    end
  end

endmodule : stack_ctrl
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stack_ctrl                                                |
// | Description : Self-checking bench for stack_ctrl: vector table of push/pop |
// |               operations, scoreboard of expected completions, plus         |
// |               sequences for round-robin, reset mid-pop and wrap/bounds.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_stack_ctrl;
  import stack_pkg::*;

  localparam int DEPTH = 1024;
  localparam int DW    = 32;
  localparam int AW    = 10;

  logic            clk;
  logic            reset;
  logic [1:0]      req;
  logic [1:0]      op;
  logic [2*DW-1:0] wdata;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic [AW:0]     sp;
  logic            full;
  logic            empty;

  stack_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .op        (op),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .sp        (sp),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, one-cycle read latency.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

`ifdef STACK_CTRL_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  typedef struct {
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
  } exp_t;

  typedef struct {
    int          idx;
    logic        opv;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          exp_sp;
  } vec_t;

  exp_t sbq[$];
  int   vecs;
  int   errs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expectation.
  task automatic mon();
    exp_t e;
    if (done != 2'b00) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = sbq.pop_front();
        chk("sb_done", 64'(done), 64'(e.done));
        if (e.chk_rd) chk("sb_rdata", 64'(rdata), 64'(e.rdata));
        chk("sb_err", 64'(err), 64'(e.err));
      end
    end else begin
      chk("idle_rdata", 64'(rdata), 64'(0));
      chk("idle_err", 64'(err), 64'(0));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    mon();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    repeat (2) step();
    reset = 1'b0;
    sbq.delete();
  endtask

  // One complete operation: request, wait for grant, check latency, RAM
  // access and the resulting stack pointer.
  task automatic do_op(input int idx, input logic opv, input logic [31:0] data,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_sp, output int waited);
    exp_t       e;
    int         lat;
    int         addr;
    logic [1:0] mask;
    mask = (idx == 1) ? 2'b10 : 2'b01;
    req[idx] = 1'b1;
    op[idx]  = opv;
    wdata[idx*DW +: DW] = data;
    #1;
    waited = 0;
    while ((gnt != mask) && (waited < 20)) begin
      step();
      #1;
      waited++;
    end
    chk("grant", 64'(gnt), 64'(mask));
    if (gnt != mask) begin
      req[idx] = 1'b0;
      return;
    end
    e.done   = mask;
    e.rdata  = exp_rd;
    e.chk_rd = (opv == OP_POP) && !exp_err;
    e.err    = exp_err;
    sbq.push_back(e);
    lat  = exp_err ? 1 : ((opv == OP_POP) ? 2 : 1);
    addr = ((opv == OP_POP) ? exp_sp : exp_sp - 1) & (DEPTH - 1);
    step();
    req[idx] = 1'b0;
    if (exp_err) begin
      chk("rej_mem_we", 64'(mem_we), 64'(0));
    end else if (opv == OP_PUSH) begin
      chk("push_we", 64'(mem_we), 64'(1));
      chk("push_addr", 64'(mem_addr), 64'(addr));
      chk("push_wdata", 64'(mem_wdata), 64'(data));
    end else begin
      chk("pop_we", 64'(mem_we), 64'(0));
      chk("pop_addr", 64'(mem_addr), 64'(addr));
    end
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) step();
      chk("done_timing", 64'(done), 64'((k == lat) ? mask : 2'b00));
      chk("no_gnt_busy", 64'(gnt), 64'(0));
    end
    step();
    chk("sp", 64'(sp), 64'(exp_sp));
    chk("empty", 64'(empty), 64'(exp_sp == 0));
    chk("full", 64'(full), 64'(BOUNDS && (exp_sp == DEPTH)));
  endtask

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    int   grants;
    logic exp_idx;
    exp_t e;

    vecs  = 0;
    errs  = 0;
    reset = 1'b1;
    req   = 2'b11;
    op    = 2'b00;
    wdata = '0;

    tbl[0] = '{0, OP_PUSH, 32'h0000_00AA, 32'h0, 1};
    tbl[1] = '{1, OP_PUSH, 32'h1234_5678, 32'h0, 2};
    tbl[2] = '{1, OP_POP,  32'h0,         32'h1234_5678, 1};
    tbl[3] = '{0, OP_PUSH, 32'hDEAD_BEEF, 32'h0, 2};
    tbl[4] = '{1, OP_PUSH, 32'h0F0F_0F0F, 32'h0, 3};
    tbl[5] = '{0, OP_POP,  32'h0,         32'h0F0F_0F0F, 2};
    tbl[6] = '{0, OP_POP,  32'h0,         32'hDEAD_BEEF, 1};
    tbl[7] = '{1, OP_POP,  32'h0,         32'h0000_00AA, 0};
    tbl[8] = '{1, OP_PUSH, 32'h1234_5678, 32'h0, 1};
    tbl[9] = '{1, OP_POP,  32'h0,         32'h1234_5678, 0};

    // Reset state, with requests asserted throughout.
    repeat (2) step();
    #1;
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_sp", 64'(sp), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    req   = 2'b00;
    reset = 1'b0;
    step();

    // Table of single-requester operations.
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].idx, tbl[i].opv, tbl[i].data, tbl[i].exp_rd, 1'b0, tbl[i].exp_sp, w);
      chk("tbl_wait", 64'(w), 64'(0));
    end

    // Continuous contention: grants alternate 0,1,0,1.
    do_reset();
    op      = 2'b00;
    wdata   = {32'h5100_0000, 32'h5000_0000};
    req     = 2'b11;
    exp_idx = 1'b0;
    grants  = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (gnt != 2'b00) begin
        chk("rr_order", 64'(gnt), 64'(exp_idx ? 2'b10 : 2'b01));
        e.done   = gnt;
        e.rdata  = 32'h0;
        e.chk_rd = 1'b0;
        e.err    = 1'b0;
        sbq.push_back(e);
        exp_idx = ~exp_idx;
        grants++;
      end
      step();
    end
    req = 2'b00;
    step();
    chk("rr_grants", 64'(grants), 64'(4));
    chk("rr_pending", 64'(sbq.size()), 64'(0));
    chk("rr_sp", 64'(sp), 64'(4));
    do_op(0, OP_POP, 32'h0, 32'h5100_0000, 1'b0, 3, w);

    // Reset while the pop is in POP_RD: abandoned with no done.
    do_reset();
    do_op(0, OP_PUSH, 32'h0000_0077, 32'h0, 1'b0, 1, w);
    req[0] = 1'b1;
    op[0]  = OP_POP;
    #1;
    chk("mid_gnt", 64'(gnt), 64'(2'b01));
    step();
    req[0] = 1'b0;
    reset  = 1'b1;
    step();
    reset  = 1'b0;
    chk("mid_done", 64'(done), 64'(0));
    chk("mid_sp", 64'(sp), 64'(0));
    chk("mid_empty", 64'(empty), 64'(1));
    do_op(1, OP_PUSH, 32'h0000_0088, 32'h0, 1'b0, 1, w);
    chk("mid_first_cycle_gnt", 64'(w), 64'(0));

    // Fill the whole stack.
    do_reset();
    if (BOUNDS) begin
      do_op(0, OP_POP, 32'h0, 32'h0, 1'b1, 0, w);
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_op(0, OP_PUSH, 32'hC000_0000 + 32'(i), 32'h0, 1'b0,
            BOUNDS ? (i + 1) : ((i + 1) % DEPTH), w);
    end
    if (BOUNDS) begin
      do_op(1, OP_PUSH, 32'hFFFF_FFFF, 32'h0, 1'b1, DEPTH, w);
    end else begin
      // Pop at sp 0 reads the top slot and wraps to DEPTH-1.
      do_op(1, OP_POP, 32'h0, 32'hC000_0000 + 32'(DEPTH - 1), 1'b0, DEPTH - 1, w);
    end
    chk("end_pending", 64'(sbq.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_stack_ctrl
`default_nettype wire

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter: DEPTH, 1024, number of 32-bit stack entries (power of two, at least 4).
REQ-002 Parameter: DW, 32, data width of requester and memory data buses.
REQ-003 Derived: AW = clog2(DEPTH).
REQ-004 Ports: clk  in  1  single clock; all logic on its rising edge.
REQ-005 Ports: reset  in  1  synchronous, active-high reset.
REQ-006 Ports: req  in  2  per-requester request; bit i belongs to requester i.
REQ-007 Ports: op  in  2  per-requester operation; 0 = push, 1 = pop.
REQ-008 Ports: wdata  in  2*DW  push data; requester i uses bits [i*DW +: DW].
REQ-009 Ports: gnt  out  2  one-cycle grant pulse, one-hot or zero.
REQ-010 Ports: done  out  2  one-cycle completion pulse to the granted requester.
REQ-011 Ports: rdata  out  DW  pop result; valid only in the cycle done is high.
REQ-012 Ports: err  out  1  rejected-operation pulse, coincident with done.
REQ-013 Ports: mem_we  out  1, mem_addr  out  AW, mem_wdata  out  DW: drive the synchronous single-port RAM.
REQ-014 Ports: mem_rdata  in  DW  RAM read data, one-cycle read latency.
REQ-015 Ports: sp  out  AW+1  current entry count; full, empty  out  1  each.

Function
REQ-016 The FSM states SHALL be IDLE, PUSH_WR, POP_RD, POP_RESP and REJECT.
REQ-017 In IDLE with any req bit set, exactly one gnt bit SHALL pulse, and the FSM SHALL leave IDLE on the next edge.
REQ-018 Arbitration SHALL be two-way round-robin: on a conflict, grant the requester not granted last; after reset, requester 0 wins the first conflict.
REQ-019 A requester SHALL hold req, op and wdata stable until its gnt, and SHALL drop req in the cycle after gnt unless it issues a new request.
REQ-020 Push latency: gnt in cycle T; in T+1 (PUSH_WR) mem_we=1, mem_addr=sp[AW-1:0], mem_wdata=latched wdata, done=1; sp increments at the end of T+1.
REQ-021 Pop latency: gnt in T; in T+1 (POP_RD) mem_addr=sp-1; in T+2 (POP_RESP) done=1, rdata=mem_rdata; sp decrements at the end of T+2.
REQ-022 PUSH_WR, POP_RESP and REJECT SHALL return to IDLE; no new gnt is issued before that return (minimum 2 cycles per push, 3 per pop).
REQ-023 Outside PUSH_WR, mem_we SHALL be 0; when done is low, rdata SHALL be 0.
REQ-024 Status: empty = (sp==0); full = (sp==DEPTH), both combinational from sp.

Reset
REQ-025 Reset SHALL set: state IDLE, sp 0, round-robin pointer to favour requester 0, and gnt, done, err, mem_we, rdata to 0.
REQ-026 Reset SHALL take priority in any state: an in-flight operation is abandoned with no done, sp returns to 0, and RAM contents are not cleared.

Configuration
REQ-027 Macro STACK_CTRL_BOUNDS_EN: when defined, a push with full=1 or a pop with empty=1 is still granted, then goes to REJECT for 1 cycle with done=1, err=1, no RAM access and sp unchanged.
REQ-028 Without STACK_CTRL_BOUNDS_EN: no checking; the REJECT state is absent; err is tied 0 and full is tied 0.
REQ-029 Without STACK_CTRL_BOUNDS_EN: sp is AW bits wide, zero-extended on the port, and wraps modulo DEPTH (a push at DEPTH-1 gives 0; a pop at 0 reads address DEPTH-1 and gives DEPTH-1).

Structure
REQ-030 Package stack_pkg SHALL hold the FSM state enum, the OP_PUSH/OP_POP constants and the default DEPTH/DW values.
REQ-031 Sub-module rr_arb2 SHALL implement the two-input round-robin arbiter (req[1:0], advance -> gnt[1:0]); no other sub-modules.

Verification
REQ-032 Scenario, after reset: r0 pushes 0x0000_00AA -> gnt[0] at T, mem_we with addr 0 and done[0] at T+1, sp=1.
REQ-033 Scenario, push then pop: r1 pushes 0x1234_5678, then pops -> done[1] at T+2 with rdata=0x1234_5678; sp back to 0 and empty=1.
REQ-034 Scenario, simultaneous requests: req=2'b11 held continuously -> grants alternate 0,1,0,1; each requester completes exactly once per grant.
REQ-035 Scenario, with STACK_CTRL_BOUNDS_EN: pop on empty -> done and err at T+1, sp stays 0; 1024 pushes, then a 1025th -> err, full=1, sp=1024.
REQ-036 Scenario, without STACK_CTRL_BOUNDS_EN: 1024 pushes -> sp wraps to 0 and err never asserts.
REQ-037 Scenario, reset mid-pop: assert reset in POP_RD -> no done; after reset sp=0, state IDLE, and the next req is granted in its first cycle.
